gamma_spike_encoder: RTL and testbench
======================================

# gamma_spike_encoder

Temporal spike encoder that drives the input side of the winner-take-all column. It accepts a vector of per-channel spike times through a valid/ready handshake. During the following gamma cycle it emits a PULSE_WIDTH-cycle pulse on each enabled channel, starting at that channel's time offset. Its output_spikes bus connects directly to the column's input_spikes.

## Interface
- GAMMA_CYCLE_WIDTH, 16: clock cycles per gamma cycle; must be ≥2.
- PULSE_WIDTH, 8: pulse length in cycles; must be ≥1.
- NUM_INPUTS, 16: number of spike channels.
- TIME_WIDTH, $clog2(GAMMA_CYCLE_WIDTH): width of each spike-time field.
- aclk  input  1  clock; all state changes on posedge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_times/in_mask hold a valid sample.
- in_ready  output  1  encoder can accept a sample this cycle.
- in_times  input  NUM_INPUTS*TIME_WIDTH  spike time per channel; channel i is bits [i*TIME_WIDTH +: TIME_WIDTH].
- in_mask  input  NUM_INPUTS  1 = channel i fires this sample; 0 = channel i is silent.
- output_spikes  output  NUM_INPUTS  registered spike pulses.
- gamma_count  output  TIME_WIDTH  position within the current gamma cycle (0..GAMMA_CYCLE_WIDTH-1).
- gamma_start  output  1  high while gamma_count==0.

## Operation
- Gamma counter:
  - Free-running; increments every cycle.
  - Wraps from GAMMA_CYCLE_WIDTH-1 to 0. The edge at which it wraps is the "wrap edge".
- Two sample registers:
  - pending: times, mask, and a full flag.
  - active: times and mask.
- Accept: a handshake occurs at a posedge with in_valid && in_ready. The sample is written to pending and pending_full is set.
- in_ready = !pending_full || (gamma_count == GAMMA_CYCLE_WIDTH-1). It is combinational from registers only and never depends on in_valid.
- At the wrap edge:
  - If pending_full, pending is copied to active. Otherwise active_mask is cleared to 0, giving a silent gamma cycle.
  - pending_full is cleared, unless a new sample is accepted at the same edge; in that case pending takes the new sample and stays full.
  - The transfer always uses the pending contents from before the edge. A sample accepted at the wrap edge fires one gamma cycle later.
- Spike rule: output_spikes[i]==1 in exactly the cycles where all of the following hold:
  - active_mask[i]==1;
  - t_i ≤ gamma_count ≤ min(t_i+PULSE_WIDTH-1, GAMMA_CYCLE_WIDTH-1).
- Pulse boundaries:
  - A pulse never spills into the next gamma cycle; it is clipped at GAMMA_CYCLE_WIDTH-1.
  - If t_i ≥ GAMMA_CYCLE_WIDTH, channel i stays silent.
  - t_i+PULSE_WIDTH is evaluated at TIME_WIDTH+$clog2(PULSE_WIDTH)+1 bits, so it cannot wrap.
- Channels are independent. Any number of channels may pulse simultaneously; no arbitration is done here.

## Timing
- Reset values:
  - gamma_count=0, gamma_start=1.
  - output_spikes=0.
  - pending_full=0, active_mask=0, so in_ready=1.
- output_spikes and gamma_count are register outputs. output_spikes is computed from the next-state count and the next-state active registers, so it is aligned with gamma_count in the same cycle.
- Latency: a sample accepted at the posedge where gamma_count goes c→c+1 (c < GAMMA_CYCLE_WIDTH-1) becomes active at the next wrap edge. The channel with t=0 goes high in the first cycle where gamma_count==0 after that edge.
- Backpressure: while pending is full, in_ready=1 only in the cycle with gamma_count==GAMMA_CYCLE_WIDTH-1. This gives a sustained throughput of one sample per gamma cycle.
- Reset asserted mid-gamma:
  - All state and outputs clear immediately; a pulse in progress is truncated.
  - After rst deasserts, the first gamma cycle is silent.

## Test plan
- Reset:
  - Assert rst asynchronously, between clock edges, while spikes are active. Required: output_spikes=0 before the next edge; gamma_count=0; in_ready=1.
- Basic encode (defaults), sample accepted at gamma_count=3:
  - Stimulus: ch0 t=0, ch1 t=5, ch2 t=12; mask=0x0007.
  - Required in the next gamma cycle: ch0 high at counts 0–7; ch1 high at 5–12; ch2 high at 12–15 (clipped); all other channels low.
  - Required in the gamma cycle after that (no new sample): all channels low.
- Backpressure, two consecutive samples A and B with in_valid held high:
  - Required: A accepted; in_ready low until gamma_count==15; B accepted at that edge.
  - Required: A fires in gamma N+1 and B fires in gamma N+2.
- Out-of-range time, GAMMA_CYCLE_WIDTH=12 (TIME_WIDTH=4):
  - Stimulus: ch3 t=13 with mask bit set.
  - Required: ch3 never pulses; gamma_count wraps 11→0.
- Accept on wrap edge with pending empty:
  - Stimulus: in_valid high only in the cycle with gamma_count==15.
  - Required: the next gamma cycle is silent; spikes appear in the gamma cycle after it.
- Full-width pulse at PULSE_WIDTH=1:
  - Stimulus: all 16 channels enabled with t=i.
  - Required: one-hot diagonal; channel i is high only at gamma_count==i.

Source files
------------

// File: rtl/gamma_spike_encoder_if.sv
// Sample handshake bundle for the gamma spike encoder: per-channel spike
// times and enable mask, offered with valid and accepted with ready.
interface gamma_spike_encoder_if #(
    parameter int NUM_INPUTS = 16,
    parameter int TIME_WIDTH = 4
);
    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] in_times;
    logic [NUM_INPUTS-1:0]            in_mask;

    // Producer side drives the sample, encoder answers with ready.
    modport master (
        output in_valid,
        output in_times,
        output in_mask,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_times,
        input  in_mask,
        output in_ready
    );
endinterface

// File: rtl/gamma_spike_encoder.sv
// Temporal spike encoder. A sample accepted during gamma cycle N is staged in
// a pending register, moved to the active register at the wrap edge, and then
// played out during gamma cycle N+1 as one pulse per enabled channel, starting
// at that channel's time offset and clipped at the end of the gamma cycle.
module gamma_spike_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int TIME_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                    aclk,
    input  logic                    rst,
    gamma_spike_encoder_if.slave    in_if,
    output logic [NUM_INPUTS-1:0]   output_spikes,
    output logic [TIME_WIDTH-1:0]   gamma_count,
    output logic                    gamma_start
);
    // Wide enough that t + PULSE_WIDTH never wraps.
    localparam int SUM_W = TIME_WIDTH + $clog2(PULSE_WIDTH) + 1;
    localparam logic [TIME_WIDTH-1:0] LAST_COUNT = TIME_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    logic [TIME_WIDTH-1:0]            gamma_count_q, gamma_count_d;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] pending_times_q, pending_times_d;
    logic [NUM_INPUTS-1:0]            pending_mask_q, pending_mask_d;
    logic                             pending_full_q, pending_full_d;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] active_times_q, active_times_d;
    logic [NUM_INPUTS-1:0]            active_mask_q, active_mask_d;
    logic [NUM_INPUTS-1:0]            spikes_q, spikes_d;
    logic                             wrap;
    logic                             accept;
    logic [SUM_W-1:0]                 count_ext;

    assign wrap           = (gamma_count_q == LAST_COUNT);
    // Ready depends only on registers: free slot, or the slot drains this edge.
    assign in_if.in_ready = !pending_full_q || wrap;
    assign accept         = in_if.in_valid && in_if.in_ready;

    assign output_spikes = spikes_q;
    assign gamma_count   = gamma_count_q;
    assign gamma_start   = (gamma_count_q == '0);

    // Next state of the gamma counter and the two sample registers.
    always_comb begin
        gamma_count_d   = wrap ? '0 : gamma_count_q + 1'b1;
        pending_times_d = pending_times_q;
        pending_mask_d  = pending_mask_q;
        pending_full_d  = pending_full_q;
        active_times_d  = active_times_q;
        active_mask_d   = active_mask_q;
        if (wrap) begin
            // Transfer uses the pre-edge pending contents; empty means silence.
            if (pending_full_q) begin
                active_times_d = pending_times_q;
                active_mask_d  = pending_mask_q;
            end else begin
                active_mask_d  = '0;
            end
            pending_full_d = 1'b0;
        end
        // A sample taken on the wrap edge refills pending after the transfer.
        if (accept) begin
            pending_times_d = in_if.in_times;
            pending_mask_d  = in_if.in_mask;
            pending_full_d  = 1'b1;
        end
    end

    // Spikes are derived from next-state count/active so they line up with
    // the registered gamma_count in the same cycle.
    assign count_ext = SUM_W'(gamma_count_d);

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
        logic [SUM_W-1:0] t_ext;
        logic [SUM_W-1:0] end_ext;
        assign t_ext   = SUM_W'(active_times_d[gi*TIME_WIDTH +: TIME_WIDTH]);
        assign end_ext = t_ext + SUM_W'(PULSE_WIDTH);
        // Count never exceeds GAMMA_CYCLE_WIDTH-1, which both clips the pulse
        // and silences channels whose time is out of range.
        assign spikes_d[gi] = active_mask_d[gi] && (count_ext >= t_ext) && (count_ext < end_ext);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            gamma_count_q   <= '0;
            pending_times_q <= '0;
            pending_mask_q  <= '0;
            pending_full_q  <= 1'b0;
            active_times_q  <= '0;
            active_mask_q   <= '0;
            spikes_q        <= '0;
        end else begin
            gamma_count_q   <= gamma_count_d;
            pending_times_q <= pending_times_d;
            pending_mask_q  <= pending_mask_d;
            pending_full_q  <= pending_full_d;
            active_times_q  <= active_times_d;
            active_mask_q   <= active_mask_d;
            spikes_q        <= spikes_d;
        end
    end
endmodule

// File: tb/tb_gamma_spike_encoder.sv
// Bench for gamma_spike_encoder: three instances (defaults, 12-cycle gamma,
// single-cycle pulses) checked every cycle against a schedule model that
// records which gamma cycle each accepted sample must play in.
`timescale 1ns/1ps
module tb_gamma_spike_encoder;
    localparam int NI = 16;
    localparam int TW = 4;
    localparam int NK = 3;
    localparam int NG = 256;

    function automatic int gw(int k);
        return (k == 1) ? 12 : 16;
    endfunction

    function automatic int pw(int k);
        return (k == 2) ? 1 : 8;
    endfunction

    logic aclk = 1'b0;
    logic rst  = 1'b1;

    logic             vld [NK];
    logic [NI*TW-1:0] tms [NK];
    logic [NI-1:0]    msk [NK];
    logic             rdy [NK];
    logic [NI-1:0]    spk [NK];
    logic [TW-1:0]    cnt [NK];
    logic             gst [NK];

    always #5 aclk = ~aclk;

    for (genvar gi = 0; gi < NK; gi++) begin : g_dut
        gamma_spike_encoder_if #(.NUM_INPUTS(NI), .TIME_WIDTH(TW)) bus ();
        assign bus.in_valid = vld[gi];
        assign bus.in_times = tms[gi];
        assign bus.in_mask  = msk[gi];
        assign rdy[gi]      = bus.in_ready;
        gamma_spike_encoder #(
            .GAMMA_CYCLE_WIDTH(gw(gi)),
            .PULSE_WIDTH(pw(gi)),
            .NUM_INPUTS(NI),
            .TIME_WIDTH(TW)
        ) dut (
            .aclk(aclk),
            .rst(rst),
            .in_if(bus),
            .output_spikes(spk[gi]),
            .gamma_count(cnt[gi]),
            .gamma_start(gst[gi])
        );
    end

    // ---------------- schedule model ----------------
    // n_m counts cycles since reset; have_m[k][g] says gamma cycle g plays a sample.
    logic             have_m [NK][NG];
    logic [NI*TW-1:0] tim_m  [NK][NG];
    logic [NI-1:0]    msk_m  [NK][NG];
    int               n_m    [NK];

    function automatic int mcount(int k);
        return n_m[k] % gw(k);
    endfunction

    function automatic int mgamma(int k);
        return n_m[k] / gw(k);
    endfunction

    // Room exists unless the next gamma already has a sample, except in the
    // last cycle where that sample leaves.
    function automatic logic mready(int k);
        return (mcount(k) == gw(k) - 1) || !have_m[k][mgamma(k) + 1];
    endfunction

    function automatic logic [NI-1:0] mspikes(int k);
        logic [NI-1:0] r;
        int g;
        int c;
        int t;
        r = '0;
        g = mgamma(k);
        c = mcount(k);
        if (have_m[k][g]) begin
            for (int i = 0; i < NI; i++) begin
                t = int'(tim_m[k][g][i*TW +: TW]);
                if (msk_m[k][g][i] && c >= t && c <= t + pw(k) - 1) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // A sample taken in the last cycle of gamma g plays in g+2, otherwise g+1.
    always @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                n_m[k] <= 0;
                for (int j = 0; j < NG; j++) have_m[k][j] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                if (vld[k] && mready(k)) begin
                    have_m[k][mgamma(k) + ((mcount(k) == gw(k) - 1) ? 2 : 1)] <= 1'b1;
                    tim_m[k][mgamma(k) + ((mcount(k) == gw(k) - 1) ? 2 : 1)]  <= tms[k];
                    msk_m[k][mgamma(k) + ((mcount(k) == gw(k) - 1) ? 2 : 1)]  <= msk[k];
                end
                n_m[k] <= n_m[k] + 1;
            end
        end
    end

    // ---------------- compare ----------------
    int errors = 0;
    int checks = 0;

    int            lit_seq = 0;
    int            seen_seq = 0;
    int            lit_k = 0;
    int            lit_c = 0;
    logic [NI-1:0] lit_exp = '0;
    string         lit_name = "";

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at t=%0t", name, k, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge aclk or posedge rst);
            if (rst) #1;
            for (int k = 0; k < NK; k++) begin
                chk("gamma_count", k, 64'(cnt[k]), 64'(mcount(k)));
                chk("gamma_start", k, 64'(gst[k]), 64'(mcount(k) == 0));
                chk("in_ready", k, 64'(rdy[k]), 64'(mready(k)));
                chk("output_spikes", k, 64'(spk[k]), 64'(mspikes(k)));
            end
            if (lit_seq != seen_seq) begin
                seen_seq = lit_seq;
                chk({lit_name, "_count"}, lit_k, 64'(cnt[lit_k]), 64'(lit_c));
                chk(lit_name, lit_k, 64'(spk[lit_k]), 64'(lit_exp));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic wait_cnt(int k, int c);
        int b;
        b = 0;
        while (mcount(k) != c) begin
            tick();
            b++;
            if (b > 200) begin
                $display("FAIL wait_cnt dut%0d: count %0d never reached", k, c);
                $fatal(1);
            end
        end
    endtask

    task automatic send(int k, int c, logic [NI*TW-1:0] t, logic [NI-1:0] m);
        wait_cnt(k, c);
        vld[k] = 1'b1;
        tms[k] = t;
        msk[k] = m;
        tick();
        vld[k] = 1'b0;
    endtask

    // Hand-computed spike vector for instance k at the next cycle with count c.
    task automatic expect_at(int k, int c, logic [NI-1:0] e, string name);
        wait_cnt(k, (c + gw(k) - 1) % gw(k));
        lit_k    = k;
        lit_c    = c;
        lit_exp  = e;
        lit_name = name;
        lit_seq  = lit_seq + 1;
    endtask

    function automatic logic [NI*TW-1:0] tset(logic [NI*TW-1:0] base, int ch, int t);
        logic [NI*TW-1:0] r;
        r = base;
        r[ch*TW +: TW] = TW'(t);
        return r;
    endfunction

    initial begin
        logic [NI*TW-1:0] tv;
        for (int k = 0; k < NK; k++) begin
            vld[k] = 1'b0;
            tms[k] = '0;
            msk[k] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        expect_at(0, 2, 16'h0000, "post_reset_silent");

        // basic encode
        tv = tset(tset(tset('0, 0, 0), 1, 5), 2, 12);
        send(0, 3, tv, 16'h0007);
        expect_at(0, 0,  16'h0001, "basic_c0");
        expect_at(0, 5,  16'h0003, "basic_c5");
        expect_at(0, 12, 16'h0006, "basic_c12");
        expect_at(0, 13, 16'h0004, "basic_c13");
        expect_at(0, 15, 16'h0004, "basic_c15");
        expect_at(0, 2,  16'h0000, "basic_next_silent");

        // backpressure: A then B with valid held
        wait_cnt(0, 5);
        vld[0] = 1'b1;
        tms[0] = tset('0, 4, 2);
        msk[0] = 16'h0010;
        tick();
        tms[0] = tset('0, 8, 3);
        msk[0] = 16'h0100;
        wait_cnt(0, 0);
        vld[0] = 1'b0;
        expect_at(0, 2, 16'h0010, "bp_A");
        wait_cnt(0, 10);
        expect_at(0, 3, 16'h0100, "bp_B");

        // accept on the wrap edge with pending empty
        send(0, 15, tset('0, 5, 1), 16'h0020);
        expect_at(0, 1, 16'h0000, "wrap_silent");
        wait_cnt(0, 10);
        expect_at(0, 1, 16'h0020, "wrap_fire");

        // out-of-range time on the 12-cycle instance
        send(1, 2, tset(tset('0, 3, 13), 0, 1), 16'h0009);
        expect_at(1, 1,  16'h0001, "oor_c1");
        expect_at(1, 11, 16'h0000, "oor_c11");
        expect_at(1, 0,  16'h0000, "oor_wrap");

        // one-hot diagonal with single-cycle pulses
        tv = '0;
        for (int i = 0; i < NI; i++) tv = tset(tv, i, i);
        send(2, 3, tv, 16'hFFFF);
        expect_at(2, 0,  16'h0001, "diag_c0");
        expect_at(2, 5,  16'h0020, "diag_c5");
        expect_at(2, 15, 16'h8000, "diag_c15");

        // asynchronous reset in the middle of a pulse
        send(0, 3, tset('0, 0, 0), 16'h0001);
        expect_at(0, 2, 16'h0001, "pre_reset");
        tick();
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_at(0, 2, 16'h0000, "post_reset2");
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
